// File: rtl/exu_stage.sv
// Execute stage of the in-order RV32 pipeline.
// Holds one instruction, computes its ALU result (serial 1-bit/cycle shifter
// for SLL/SRL/SRA), raises a one-shot branch redirect and exports the held
// rd/csr target so the register-fetch stage can detect hazards.
module exu_stage #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            excp_flush,
   input  logic            mret_flush,
   input  logic            rfu_valid_i,
   output logic            exu_ready_o,
   input  logic [XLEN-1:0] pc_i,
   input  logic [4:0]      rd_i,
   input  logic            branch_i,
   input  logic [2:0]      alu_op_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   input  logic [XLEN-1:0] rs2_value_i,
   input  logic            res_from_mem_i,
   input  logic            res_from_pre_i,
   input  logic [XLEN-1:0] pre_result_i,
   input  logic [3:0]      mem_re_i,
   input  logic [3:0]      mem_we_i,
   input  logic            gr_we_i,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   input  logic            lsu_ready_i,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [3:0]      mem_re_o,
   output logic [3:0]      mem_we_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [4:0]      rd_o,
   output logic            gr_we_o,
   output logic            csr_we_o,
   output logic [11:0]     csr_addr_o,
   output logic [XLEN-1:0] csr_wdata_o,
   output logic            res_from_mem_o,
   output logic [XLEN-1:0] pc_o,
   output logic            branch_flush_o,
   output logic [XLEN-1:0] branch_target_o,
   output logic            exu_valid_o,
   output logic [4:0]      exu_rd_o,
   output logic [11:0]     exu_csr_addr_o
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_SLL = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_SRL = 3'd4;
   localparam logic [2:0] OP_SRA = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_AND = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            redir_q, redir_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d;

   // instruction fields captured on accept
   logic [XLEN-1:0] pc_q, src1_q, src2_q, rs2_q, pre_q, csr_wdata_q;
   logic [4:0]      rd_q;
   logic [2:0]      op_q;
   logic            branch_q, rfm_q, rfp_q, gr_we_q, csr_we_q;
   logic [3:0]      mem_re_q, mem_we_q;
   logic [11:0]     csr_addr_q;

   logic            valid_s, done_s, flush_s, accept_s, leave_s, shift_in_s;
   logic            bflush_s;
   logic [XLEN-1:0] add_s, alu_s, shift_step_s;

   assign valid_s    = (state_q != ST_IDLE);
   assign done_s     = (state_q == ST_EXEC);
   assign flush_s    = excp_flush | mret_flush;
   assign exu_ready_o = !valid_s || (done_s && lsu_ready_i);
   // a flush cancels any accept offered in the same cycle
   assign accept_s   = rfu_valid_i && exu_ready_o && !flush_s;
   assign valid_o    = valid_s && done_s && !flush_s;
   assign leave_s    = valid_o && lsu_ready_i;
   assign shift_in_s = (alu_op_i == OP_SLL) || (alu_op_i == OP_SRL) || (alu_op_i == OP_SRA);
   assign bflush_s   = valid_s && done_s && branch_q && !redir_q;
   assign add_s      = src1_q + src2_q;

   // Single-cycle ALU; shift ops read the serial accumulator instead.
   always_comb begin
      alu_s = '0;
      case (op_q)
         OP_ADD:  alu_s = add_s;
         OP_SUB:  alu_s = src1_q - src2_q;
         OP_XOR:  alu_s = src1_q ^ src2_q;
         OP_OR:   alu_s = src1_q | src2_q;
         OP_AND:  alu_s = src1_q & src2_q;
         default: alu_s = acc_q;
      endcase
   end

   // One-bit shift of the accumulator for the held shift op.
   always_comb begin
      shift_step_s = acc_q;
      case (op_q)
         OP_SLL:  shift_step_s = {acc_q[XLEN-2:0], 1'b0};
         OP_SRL:  shift_step_s = {1'b0, acc_q[XLEN-1:1]};
         OP_SRA:  shift_step_s = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
         default: shift_step_s = acc_q;
      endcase
   end

   // Next state: flush wins, then accept, then leave, then shift progress.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      redir_d = redir_q;
      if (flush_s) begin
         state_d = ST_IDLE;
         redir_d = 1'b0;
      end else if (accept_s) begin
         acc_d   = src1_i;
         redir_d = 1'b0;
         if (shift_in_s && (src2_i[SHW-1:0] != '0)) begin
            state_d = ST_SHIFT;
            cnt_d   = src2_i[SHW-1:0];
         end else begin
            state_d = ST_EXEC;
            cnt_d   = '0;
         end
      end else if (leave_s) begin
         state_d = ST_IDLE;
         redir_d = 1'b0;
      end else begin
         if (bflush_s) begin
            redir_d = 1'b1;
         end else begin
            redir_d = redir_q;
         end
         case (state_q)
            ST_SHIFT: begin
               acc_d = shift_step_s;
               cnt_d = cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         redir_q <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         redir_q <= redir_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   // Capture the instruction fields on accept, hold them otherwise.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q        <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         rs2_q       <= '0;
         pre_q       <= '0;
         csr_wdata_q <= '0;
         rd_q        <= 5'd0;
         op_q        <= 3'd0;
         branch_q    <= 1'b0;
         rfm_q       <= 1'b0;
         rfp_q       <= 1'b0;
         gr_we_q     <= 1'b0;
         csr_we_q    <= 1'b0;
         mem_re_q    <= 4'd0;
         mem_we_q    <= 4'd0;
         csr_addr_q  <= 12'd0;
      end else if (accept_s) begin
         pc_q        <= pc_i;
         src1_q      <= src1_i;
         src2_q      <= src2_i;
         rs2_q       <= rs2_value_i;
         pre_q       <= pre_result_i;
         csr_wdata_q <= csr_wdata_i;
         rd_q        <= rd_i;
         op_q        <= alu_op_i;
         branch_q    <= branch_i;
         rfm_q       <= res_from_mem_i;
         rfp_q       <= res_from_pre_i;
         gr_we_q     <= gr_we_i;
         csr_we_q    <= csr_we_i;
         mem_re_q    <= mem_re_i;
         mem_we_q    <= mem_we_i;
         csr_addr_q  <= csr_addr_i;
      end
   end

   assign result_o        = rfp_q ? pre_q : alu_s;
   assign mem_re_o        = mem_re_q;
   assign mem_we_o        = mem_we_q;
   assign mem_wdata_o     = rs2_q;
   assign rd_o            = rd_q;
   assign gr_we_o         = gr_we_q;
   assign csr_we_o        = csr_we_q;
   assign csr_addr_o      = csr_addr_q;
   assign csr_wdata_o     = csr_wdata_q;
   assign res_from_mem_o  = rfm_q;
   assign pc_o            = pc_q;
   assign branch_flush_o  = bflush_s;
   assign branch_target_o = branch_q ? add_s : '0;
   assign exu_valid_o     = valid_s;
   assign exu_rd_o        = gr_we_q ? rd_q : 5'd0;
   assign exu_csr_addr_o  = csr_we_q ? csr_addr_q : 12'd0;

endmodule

// File: tb/tb_exu_stage.sv
// Self-checking bench for exu_stage: directed scenarios plus randomized
// traffic, checked against a transaction-level reference model.
module tb_exu_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        excp_flush, mret_flush, rfu_valid_i, lsu_ready_i;
   logic        exu_ready_o;
   logic [31:0] pc_i, src1_i, src2_i, rs2_value_i, pre_result_i, csr_wdata_i;
   logic [4:0]  rd_i;
   logic        branch_i, res_from_mem_i, res_from_pre_i, gr_we_i, csr_we_i;
   logic [2:0]  alu_op_i;
   logic [3:0]  mem_re_i, mem_we_i;
   logic [11:0] csr_addr_i;
   logic        valid_o, gr_we_o, csr_we_o, res_from_mem_o, branch_flush_o, exu_valid_o;
   logic [31:0] result_o, mem_wdata_o, csr_wdata_o, pc_o, branch_target_o;
   logic [3:0]  mem_re_o, mem_we_o;
   logic [4:0]  rd_o, exu_rd_o;
   logic [11:0] csr_addr_o, exu_csr_addr_o;

   always #5 clock = ~clock;

   exu_stage #(.XLEN(32)) dut (
      .clock(clock), .reset(reset), .excp_flush(excp_flush), .mret_flush(mret_flush),
      .rfu_valid_i(rfu_valid_i), .exu_ready_o(exu_ready_o), .pc_i(pc_i), .rd_i(rd_i),
      .branch_i(branch_i), .alu_op_i(alu_op_i), .src1_i(src1_i), .src2_i(src2_i),
      .rs2_value_i(rs2_value_i), .res_from_mem_i(res_from_mem_i), .res_from_pre_i(res_from_pre_i),
      .pre_result_i(pre_result_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .gr_we_i(gr_we_i),
      .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
      .lsu_ready_i(lsu_ready_i), .valid_o(valid_o), .result_o(result_o), .mem_re_o(mem_re_o),
      .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .rd_o(rd_o), .gr_we_o(gr_we_o),
      .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
      .res_from_mem_o(res_from_mem_o), .pc_o(pc_o), .branch_flush_o(branch_flush_o),
      .branch_target_o(branch_target_o), .exu_valid_o(exu_valid_o), .exu_rd_o(exu_rd_o),
      .exu_csr_addr_o(exu_csr_addr_o)
   );

   typedef struct {
      logic [31:0] pc, src1, src2, rs2, pre, cwd;
      logic [4:0]  rd;
      logic [2:0]  op;
      logic        br, rfm, rfp, gwe, cwe;
      logic [3:0]  re, we;
      logic [11:0] ca;
   } ins_t;

   int   total = 0;
   int   bad   = 0;
   ins_t cur;           // instruction currently offered upstream
   logic cur_valid, cur_lsu, cur_excp, cur_mret;

   // reference model: held instruction, remaining shift cycles, redirect issued
   logic m_hold, m_redir;
   int   m_wait;
   ins_t m_ins;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input ins_t t);
      logic [31:0] r;
      logic [4:0]  sh;
      sh = t.src2[4:0];
      case (t.op)
         3'd0:    r = t.src1 + t.src2;
         3'd1:    r = t.src1 - t.src2;
         3'd2:    r = t.src1 << sh;
         3'd3:    r = t.src1 ^ t.src2;
         3'd4:    r = t.src1 >> sh;
         3'd5:    r = $signed(t.src1) >>> sh;
         3'd6:    r = t.src1 | t.src2;
         default: r = t.src1 & t.src2;
      endcase
      return t.rfp ? t.pre : r;
   endfunction

   task automatic apply();
      rfu_valid_i = cur_valid;  lsu_ready_i = cur_lsu;
      excp_flush = cur_excp;    mret_flush = cur_mret;
      pc_i = cur.pc;            src1_i = cur.src1;       src2_i = cur.src2;
      rs2_value_i = cur.rs2;    pre_result_i = cur.pre;  csr_wdata_i = cur.cwd;
      rd_i = cur.rd;            alu_op_i = cur.op;       branch_i = cur.br;
      res_from_mem_i = cur.rfm; res_from_pre_i = cur.rfp;
      gr_we_i = cur.gwe;        csr_we_i = cur.cwe;
      mem_re_i = cur.re;        mem_we_i = cur.we;       csr_addr_i = cur.ca;
   endtask

   // directed instruction with random side fields
   task automatic set_ins(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic br, input logic gwe, input logic [4:0] rd);
      cur.op = op;  cur.src1 = a;  cur.src2 = b;  cur.br = br;  cur.gwe = gwe;  cur.rd = rd;
      cur.pc = $urandom;  cur.rs2 = $urandom;  cur.pre = $urandom;  cur.cwd = $urandom;
      cur.rfm = 1'($urandom);  cur.rfp = 1'b0;  cur.cwe = 1'($urandom);
      cur.re = 4'($urandom);  cur.we = 4'($urandom);  cur.ca = 12'($urandom);
      apply();
   endtask

   task automatic model_reset();
      m_hold = 1'b0;  m_redir = 1'b0;  m_wait = 0;
   endtask

   // check one cycle against the model, then advance DUT and model one edge
   task automatic step();
      logic done, fl, ev, er, eb, acc, leave;
      apply();
      #1;
      done = m_hold && (m_wait == 0);
      fl   = cur_excp | cur_mret;
      ev   = done && !fl;
      er   = !m_hold || (done && cur_lsu);
      eb   = done && m_ins.br && !m_redir;
      chk("valid_o", valid_o, ev);
      chk("exu_ready_o", exu_ready_o, er);
      chk("branch_flush_o", branch_flush_o, eb);
      chk("exu_valid_o", exu_valid_o, m_hold);
      if (m_hold) begin
         chk("exu_rd_o", exu_rd_o, m_ins.gwe ? m_ins.rd : 5'd0);
         chk("exu_csr_addr_o", exu_csr_addr_o, m_ins.cwe ? m_ins.ca : 12'd0);
      end
      if (ev) begin
         chk("result_o", result_o, ref_result(m_ins));
         chk("pc_o", pc_o, m_ins.pc);
         chk("mem_wdata_o", mem_wdata_o, m_ins.rs2);
         chk("mem_re_o", mem_re_o, m_ins.re);
         chk("mem_we_o", mem_we_o, m_ins.we);
         chk("rd_o", rd_o, m_ins.rd);
         chk("gr_we_o", gr_we_o, m_ins.gwe);
         chk("csr_we_o", csr_we_o, m_ins.cwe);
         chk("csr_addr_o", csr_addr_o, m_ins.ca);
         chk("csr_wdata_o", csr_wdata_o, m_ins.cwd);
         chk("res_from_mem_o", res_from_mem_o, m_ins.rfm);
      end
      if (eb) chk("branch_target_o", branch_target_o, m_ins.src1 + m_ins.src2);
      @(posedge clock);
      acc   = cur_valid && er && !fl;
      leave = ev && cur_lsu;
      if (fl) begin
         model_reset();
      end else if (acc) begin
         m_ins   = cur;
         m_hold  = 1'b1;
         m_redir = 1'b0;
         m_wait  = ((cur.op == 3'd2 || cur.op == 3'd4 || cur.op == 3'd5)) ? int'(cur.src2[4:0]) : 0;
      end else if (leave) begin
         m_hold  = 1'b0;
         m_redir = 1'b0;
      end else begin
         if (eb) m_redir = 1'b1;
         if (m_wait > 0) m_wait--;
      end
      #1;
   endtask

   initial begin
      int pulses;
      logic [31:0] tp_a [3] = '{32'hFFFF_FFFF, 32'd3, 32'h0000_00F0};
      logic [31:0] tp_b [3] = '{32'd1, 32'd5, 32'h0000_003C};
      logic [2:0]  tp_op[3] = '{3'd0, 3'd1, 3'd7};
      logic [31:0] tp_r [3] = '{32'd0, 32'hFFFF_FFFE, 32'h0000_0030};

      cur = '{default: '0};
      cur_valid = 1'b0;  cur_lsu = 1'b0;  cur_excp = 1'b0;  cur_mret = 1'b0;
      apply();
      model_reset();
      m_ins = '{default: '0};
      reset = 1'b0;
      #3;
      chk("rst_valid_o", valid_o, 32'd0);
      chk("rst_ready", exu_ready_o, 32'd1);
      chk("rst_result", result_o, 32'd0);
      chk("rst_bflush", branch_flush_o, 32'd0);
      chk("rst_target", branch_target_o, 32'd0);
      chk("rst_exu_valid", exu_valid_o, 32'd0);
      chk("rst_exu_rd", exu_rd_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;

      // asynchronous reset in the middle of a serial shift
      cur_lsu = 1'b1;  cur_valid = 1'b1;
      set_ins(3'd2, 32'h1, 32'd10, 1'b0, 1'b1, 5'd3);
      step();
      cur_valid = 1'b0;
      step();
      step();
      #2 reset = 1'b0;
      #1;
      chk("arst_valid_o", valid_o, 32'd0);
      chk("arst_ready", exu_ready_o, 32'd1);
      chk("arst_exu_valid", exu_valid_o, 32'd0);
      model_reset();
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;

      // ADD 5+7 with gr_we=0, rd=5
      cur_valid = 1'b1;
      set_ins(3'd0, 32'd5, 32'd7, 1'b0, 1'b0, 5'd5);
      step();
      chk("add_valid", valid_o, 32'd1);
      chk("add_result", result_o, 32'd12);
      chk("rd_masked", exu_rd_o, 32'd0);

      // back-to-back single-cycle ops
      for (int i = 0; i < 3; i++) begin
         set_ins(tp_op[i], tp_a[i], tp_b[i], 1'b0, 1'b1, 5'(i + 1));
         step();
         chk("tput_valid", valid_o, 32'd1);
         chk("tput_result", result_o, tp_r[i]);
      end
      cur_valid = 1'b0;
      step();

      // SRA by 4, then SLL by 0 (src2[4:0]==0)
      cur_valid = 1'b1;
      set_ins(3'd5, 32'h8000_0000, 32'd4, 1'b0, 1'b1, 5'd7);
      step();
      cur_valid = 1'b0;  apply();
      for (int k = 0; k < 4; k++) begin
         chk("sra_busy_valid", valid_o, 32'd0);
         chk("sra_busy_ready", exu_ready_o, 32'd0);
         step();
      end
      chk("sra_valid", valid_o, 32'd1);
      chk("sra_result", result_o, 32'hF800_0000);
      cur_valid = 1'b1;
      set_ins(3'd2, 32'h0000_1234, 32'h0000_0020, 1'b0, 1'b1, 5'd8);
      step();
      chk("sll0_valid", valid_o, 32'd1);
      chk("sll0_result", result_o, 32'h0000_1234);
      cur_valid = 1'b0;
      step();

      // redirect under LSU backpressure, gr_we=1 rd=5 held for the stall
      cur_valid = 1'b1;  cur_lsu = 1'b0;
      set_ins(3'd0, 32'h8000_0000, 32'h10, 1'b1, 1'b1, 5'd5);
      step();
      cur_valid = 1'b0;  apply();
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) chk("redir_target", branch_target_o, 32'h8000_0010);
         if (branch_flush_o === 1'b1) pulses++;
         chk("redir_hold_valid", valid_o, 32'd1);
         chk("stall_rd", exu_rd_o, 32'd5);
         step();
      end
      cur_lsu = 1'b1;  apply();
      if (branch_flush_o === 1'b1) pulses++;
      chk("redir_leave_valid", valid_o, 32'd1);
      step();
      chk("redir_pulses", pulses, 32'd1);

      // exception flush during a shift with upstream valid
      cur_valid = 1'b1;
      set_ins(3'd4, 32'hF000_0000, 32'd8, 1'b0, 1'b1, 5'd9);
      step();
      set_ins(3'd0, 32'd1, 32'd2, 1'b0, 1'b1, 5'd10);
      cur_excp = 1'b1;  apply();
      chk("flush_valid_o", valid_o, 32'd0);
      step();
      cur_excp = 1'b0;  cur_valid = 1'b0;  apply();
      chk("flush_exu_valid", exu_valid_o, 32'd0);
      chk("flush_valid_after", valid_o, 32'd0);
      step();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         cur.op   = 3'($urandom_range(0, 7));
         cur.src1 = $urandom;
         cur.src2 = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 6));
         cur.pc   = $urandom;  cur.rs2 = $urandom;  cur.pre = $urandom;  cur.cwd = $urandom;
         cur.rd   = 5'($urandom);  cur.br = ($urandom_range(0, 3) == 0);
         cur.rfm  = 1'($urandom);  cur.rfp = ($urandom_range(0, 4) == 0);
         cur.gwe  = 1'($urandom);  cur.cwe = 1'($urandom);
         cur.re   = 4'($urandom);  cur.we = 4'($urandom);  cur.ca = 12'($urandom);
         cur_valid = ($urandom_range(0, 9) < 7);
         cur_lsu   = ($urandom_range(0, 9) < 7);
         cur_excp  = ($urandom_range(0, 29) == 0);
         cur_mret  = ($urandom_range(0, 29) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
